// File: rtl/mips_interrupt_controller.sv
// Interrupt requester for the multi-cycle MIPS core: edge capture, masking, priority, INT/NMI/INA/INTD handshake.
// Optional acknowledge timeout and ack_timeout_o port are enabled by defining MIPS_INTC_ACK_TIMEOUT_EN.
module mips_interrupt_controller #(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               nmi_src_i,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               eoi,
  input  logic               INA,
  output logic               INT,
  output logic               NMI,
  output logic               INTD,
  output logic [VEC_W-1:0]   vec_o,
  output logic [NUM_IRQ-1:0] pending_o,
  output logic               busy_o
`ifdef MIPS_INTC_ACK_TIMEOUT_EN
  ,
  output logic               ack_timeout_o
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ_INT = 3'd1;
  localparam logic [2:0] S_REQ_NMI = 3'd2;
  localparam logic [2:0] S_ACK     = 3'd3;
  localparam logic [2:0] S_SERVICE = 3'd4;
  localparam logic [VEC_W-1:0] NMI_VEC = VEC_W'(NUM_IRQ);

  if (NUM_IRQ < 2 || NUM_IRQ > 16 || (2 ** VEC_W) < NUM_IRQ + 1 || TIMEOUT < 1) begin : g_bad_params
    $error("mips_interrupt_controller: illegal parameter combination");
  end

  logic [NUM_IRQ-1:0] irq_smp_r, irq_prev_r, pending_r, mask_r;
  logic               nmi_smp_r, nmi_prev_r, nmi_pend_r;
  logic [2:0]         state_r, state_s;
  logic [VEC_W-1:0]   win_r, win_s, lowest_s, in_svc_r, saved_r, vec_r;
  logic               in_svc_vld_r, saved_vld_r;
  logic               int_r, nmi_r, intd_r, busy_r;
  logic [NUM_IRQ-1:0] irq_rise_s, elig_s, win_oh_s, clr_s;
  logic               nmi_rise_s, cancel_s, timeout_hit_s;
  logic               ack_irq_s, ack_nmi_s, eoi_s, nest_s;

  assign irq_rise_s = irq_smp_r & ~irq_prev_r;
  assign nmi_rise_s = nmi_smp_r & ~nmi_prev_r;
  assign elig_s     = pending_r & mask_r;
  assign win_oh_s   = {{(NUM_IRQ-1){1'b0}}, 1'b1} << win_r;
  assign cancel_s   = ((mask_r & win_oh_s) == {NUM_IRQ{1'b0}});
  assign clr_s      = ack_irq_s ? win_oh_s : {NUM_IRQ{1'b0}};

  // Lowest-index eligible request wins.
  always_comb begin
    lowest_s = {VEC_W{1'b0}};
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig_s[i]) lowest_s = VEC_W'(i);
      else           lowest_s = lowest_s;
    end
  end

  // Handshake state machine next-state and event decode.
  always_comb begin
    state_s   = state_r;
    win_s     = win_r;
    ack_irq_s = 1'b0;
    ack_nmi_s = 1'b0;
    eoi_s     = 1'b0;
    nest_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (nmi_pend_r) begin
          state_s = S_REQ_NMI;
          win_s   = NMI_VEC;
        end else if ((elig_s != {NUM_IRQ{1'b0}}) && !in_svc_vld_r) begin
          state_s = S_REQ_INT;
          win_s   = lowest_s;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ_INT: begin
        if (INA) begin
          state_s   = S_ACK;
          ack_irq_s = 1'b1;
        end else if (cancel_s || timeout_hit_s) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_REQ_INT;
        end
      end
      S_REQ_NMI: begin
        if (INA) begin
          state_s   = S_ACK;
          ack_nmi_s = 1'b1;
        end else if (timeout_hit_s) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_REQ_NMI;
        end
      end
      S_ACK: state_s = S_SERVICE;
      S_SERVICE: begin
        if (eoi) begin
          eoi_s   = 1'b1;
          state_s = saved_vld_r ? S_SERVICE : S_IDLE;
        end else if (nmi_pend_r && (in_svc_r != NMI_VEC) && !saved_vld_r) begin
          // NMI preempts a serviced IRQ; the IRQ is parked in the one-deep slot.
          nest_s  = 1'b1;
          state_s = S_REQ_NMI;
          win_s   = NMI_VEC;
        end else begin
          state_s = S_SERVICE;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Input sampling, pending/mask registers, FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_smp_r    <= {NUM_IRQ{1'b0}};
      irq_prev_r   <= {NUM_IRQ{1'b0}};
      pending_r    <= {NUM_IRQ{1'b0}};
      mask_r       <= {NUM_IRQ{1'b0}};
      nmi_smp_r    <= 1'b0;
      nmi_prev_r   <= 1'b0;
      nmi_pend_r   <= 1'b0;
      state_r      <= S_IDLE;
      win_r        <= {VEC_W{1'b0}};
      in_svc_r     <= {VEC_W{1'b0}};
      in_svc_vld_r <= 1'b0;
      saved_r      <= {VEC_W{1'b0}};
      saved_vld_r  <= 1'b0;
      vec_r        <= {VEC_W{1'b0}};
      int_r        <= 1'b0;
      nmi_r        <= 1'b0;
      intd_r       <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      irq_smp_r  <= irq_i;
      irq_prev_r <= irq_smp_r;
      nmi_smp_r  <= nmi_src_i;
      nmi_prev_r <= nmi_smp_r;
      if (mask_we) mask_r <= mask_wdata;
      // A fresh edge on the source being acknowledged re-arms it.
      pending_r  <= (pending_r & ~clr_s) | irq_rise_s;
      nmi_pend_r <= (nmi_pend_r & ~ack_nmi_s) | nmi_rise_s;
      state_r    <= state_s;
      win_r      <= win_s;
      int_r      <= (state_s == S_REQ_INT);
      nmi_r      <= (state_s == S_REQ_NMI);
      intd_r     <= (state_s == S_ACK);
      busy_r     <= (state_s != S_IDLE);
      if (ack_irq_s || ack_nmi_s) begin
        vec_r        <= win_r;
        in_svc_r     <= win_r;
        in_svc_vld_r <= 1'b1;
      end else if (eoi_s && saved_vld_r) begin
        in_svc_r    <= saved_r;
        saved_vld_r <= 1'b0;
      end else if (eoi_s) begin
        in_svc_vld_r <= 1'b0;
      end else if (nest_s) begin
        saved_r     <= in_svc_r;
        saved_vld_r <= 1'b1;
      end
    end
  end

`ifdef MIPS_INTC_ACK_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_r;
  logic             ack_timeout_r;

  assign timeout_hit_s = (cnt_r == CNT_W'(TIMEOUT - 1));
  assign ack_timeout_o = ack_timeout_r;

  // Acknowledge-wait counter, cleared whenever the FSM is not holding a request.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r         <= {CNT_W{1'b0}};
      ack_timeout_r <= 1'b0;
    end else begin
      if (((state_r == S_REQ_INT) || (state_r == S_REQ_NMI)) && (state_s == state_r))
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      else
        cnt_r <= {CNT_W{1'b0}};
      ack_timeout_r <= timeout_hit_s && !INA &&
                       ((state_r == S_REQ_NMI) || ((state_r == S_REQ_INT) && !cancel_s));
    end
  end
`else
  assign timeout_hit_s = 1'b0;
`endif

  assign INT       = int_r;
  assign NMI       = nmi_r;
  assign INTD      = intd_r;
  assign vec_o     = vec_r;
  assign pending_o = pending_r;
  assign busy_o    = busy_r;

endmodule
